// File: rtl/rf_wport_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_wport_arbiter_pkg
// Description : Shared widths and the buffered MDU result entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_wport_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } wport_entry_t;

endpackage
`default_nettype wire

// File: rtl/rf_wport_arbiter_wport_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wport_fifo
// Description : MDU result buffer with per-entry valid bits and address kill.
// Revision    : 1.0 - initial release
// ============================================================================
module wport_fifo
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int COUNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  wport_entry_t       push_entry,
    input  logic               pop,
    input  logic               kill_en,
    input  logic [REG_W-1:0]   kill_addr,
    output wport_entry_t       head,
    output logic [COUNT_W-1:0] count
);

    wport_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [COUNT_W-1:0] r_count;

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].valid <= 1'b0;
            end
        end else begin
            // A younger WB write to the same register supersedes the buffered result.
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && r_mem[i].valid && (r_mem[i].addr == kill_addr)) begin
                    r_mem[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                r_mem[r_rd_ptr].valid <= 1'b0;
                r_rd_ptr              <= r_rd_ptr + 1'b1;
            end
            if (push) begin
                r_mem[r_wr_ptr] <= push_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wport_arbiter
// Description : Regfile write-port arbiter: WB priority, buffered MDU results.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [REG_W-1:0]  wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [REG_W-1:0]  mdu_waddr,
    input  logic [DATA_W-1:0] mdu_wdata,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stall_req,
    output logic              mdu_pending
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;
    localparam logic [COUNT_W-1:0] c_DEPTH    = COUNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   c_MAX_WAIT = CNT_W'(MAX_WAIT);

    logic               w_wb_act;
    logic               w_push;
    logic               w_pop;
    wport_entry_t       w_push_entry;
    wport_entry_t       w_head;
    logic [COUNT_W-1:0] w_count;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_stall_req;

    assign w_wb_act    = wb_we && (wb_waddr != REG_ZERO);
    assign mdu_ready   = (w_count < c_DEPTH);
    assign mdu_pending = (w_count != '0);
    assign w_push      = mdu_valid && mdu_ready;
    assign w_pop       = !w_wb_act && mdu_pending;
    assign stall_req   = r_stall_req;

    // $0 results and results already overwritten by this cycle's WB go in invalid.
    assign w_push_entry.valid = (mdu_waddr != REG_ZERO)
                              && !(w_wb_act && (mdu_waddr == wb_waddr));
    assign w_push_entry.addr  = mdu_waddr;
    assign w_push_entry.data  = mdu_wdata;

    wport_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .kill_en    (w_wb_act),
        .kill_addr  (wb_waddr),
        .head       (w_head),
        .count      (w_count)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = REG_ZERO;
        rf_wdata = '0;
        if (w_wb_act) begin
            rf_we    = !rst;
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
        end else if (mdu_pending && w_head.valid) begin
            rf_we    = !rst;
            rf_waddr = w_head.addr;
            rf_wdata = w_head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt  <= '0;
            r_stall_req <= 1'b0;
        end else begin
            if (w_pop || !mdu_pending) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt < c_MAX_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_pop) begin
                r_stall_req <= 1'b0;
            end else if (r_wait_cnt == c_MAX_WAIT) begin
                r_stall_req <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wport_arbiter
// Description : Directed self-checking bench for rf_wport_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_waddr;
    logic [31:0] mdu_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic        mdu_pending;

    int errors = 0;
    int checks = 0;

    rf_wport_arbiter #(
        .DEPTH    (2),
        .MAX_WAIT (4),
        .CNT_W    (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_we       (wb_we),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .mdu_valid   (mdu_valid),
        .mdu_ready   (mdu_ready),
        .mdu_waddr   (mdu_waddr),
        .mdu_wdata   (mdu_wdata),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .stall_req   (stall_req),
        .mdu_pending (mdu_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after the falling edge; outputs are sampled 2ns later.
    task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        @(negedge clk);
        rst = r; wb_we = we; wb_waddr = wa; wb_wdata = wd;
        mdu_valid = mv; mdu_waddr = ma; mdu_wdata = md;
        #2;
    endtask

    initial begin
        rst = 1'b1; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
        mdu_valid = 1'b0; mdu_waddr = '0; mdu_wdata = '0;
        repeat (2) @(posedge clk);

        // Reset state and WB pass-through
        drive(0, 1, 5'd5, 32'h1234, 0, 0, 0);
        check("t1_rf_we", rf_we, 1);
        check("t1_rf_waddr", rf_waddr, 5);
        check("t1_rf_wdata", rf_wdata, 32'h1234);
        check("t1_stall", stall_req, 0);
        check("t1_ready", mdu_ready, 1);
        check("t1_pending", mdu_pending, 0);

        // MDU result drains one cycle after acceptance
        drive(0, 0, 0, 0, 1, 5'd8, 32'hCAFE);
        check("t2_no_bypass", rf_we, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t2_rf_we", rf_we, 1);
        check("t2_rf_waddr", rf_waddr, 8);
        check("t2_rf_wdata", rf_wdata, 32'hCAFE);
        check("t2_pending", mdu_pending, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t2_pending_drop", mdu_pending, 0);
        check("t2_idle_we", rf_we, 0);

        // Starvation: WB hogs the port, stall asserts, bubble drains head
        drive(0, 1, 5'd1, 32'h1, 1, 5'd10, 32'hA);
        check("t3_ready0", mdu_ready, 1);
        drive(0, 1, 5'd1, 32'h1, 1, 5'd11, 32'hB);
        check("t3_ready1", mdu_ready, 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 5'd1, 32'h1, 0, 0, 0);
            check("t3_stall_early", stall_req, 0);
            check("t3_ready_full", mdu_ready, 0);
            check("t3_wb_wins", rf_waddr, 1);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t3_stall", stall_req, 1);
        check("t3_head_addr", rf_waddr, 10);
        check("t3_head_data", rf_wdata, 32'hA);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t3_stall_clr", stall_req, 0);
        check("t3_second_addr", rf_waddr, 11);
        check("t3_second_we", rf_we, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t3_empty", mdu_pending, 0);

        // WAW kill of a buffered entry
        drive(0, 1, 5'd2, 32'h2, 1, 5'd9, 32'h99);
        drive(0, 1, 5'd9, 32'h1999, 0, 0, 0);
        check("t4_wb_addr", rf_waddr, 9);
        check("t4_wb_data", rf_wdata, 32'h1999);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t4_silent_pop", rf_we, 0);
        check("t4_still_pending", mdu_pending, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t4_popped", mdu_pending, 0);
        check("t4_never_written", rf_we, 0);

        // $0 MDU result occupies a slot but never writes
        drive(0, 0, 0, 0, 1, 5'd0, 32'h55);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t5_zero_pending", mdu_pending, 1);
        check("t5_zero_we", rf_we, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t5_zero_popped", mdu_pending, 0);

        // WB to $0 yields the port to the buffered head
        drive(0, 0, 0, 0, 1, 5'd12, 32'hC);
        drive(0, 1, 5'd0, 32'hDEAD, 0, 0, 0);
        check("t5_drain_we", rf_we, 1);
        check("t5_drain_addr", rf_waddr, 12);
        check("t5_drain_data", rf_wdata, 32'hC);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t5_drain_done", mdu_pending, 0);

        // Same-cycle push with matching WB address is stored dead
        drive(0, 1, 5'd13, 32'h13, 1, 5'd13, 32'h77);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t5_push_kill_we", rf_we, 0);
        check("t5_push_kill_pend", mdu_pending, 1);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Simultaneous push and pop keeps the stream ordered
        drive(0, 0, 0, 0, 1, 5'd16, 32'h10);
        drive(0, 0, 0, 0, 1, 5'd17, 32'h11);
        check("t5_pp_first", rf_waddr, 16);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t5_pp_second", rf_wdata, 32'h11);
        check("t5_pp_pending", mdu_pending, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t5_pp_empty", mdu_pending, 0);

        // Reset with a full buffer
        drive(0, 1, 5'd1, 32'h1, 1, 5'd14, 32'hE);
        drive(0, 1, 5'd1, 32'h1, 1, 5'd15, 32'hF);
        drive(1, 1, 5'd3, 32'h3, 0, 0, 0);
        check("t6_full", mdu_ready, 0);
        check("t6_rst_we", rf_we, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t6_pending", mdu_pending, 0);
        check("t6_ready", mdu_ready, 1);
        check("t6_stall", stall_req, 0);
        check("t6_no_stale", rf_we, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Arbitrates the single register-file write port between the pipeline WriteBack stage and a multi-cycle multiply/divide unit (MDU).
- WB has fixed priority. MDU results are buffered in a small FIFO and drained in cycles where WB does not write.
- A starvation counter requests a pipeline stall so that buffered results cannot wait forever.
- Sits between the WB-stage outputs, the MDU result port and the regfile write port.

Parameters:
- DEPTH, 2, MDU result buffer entries (power of two, at least 2).
- MAX_WAIT, 4, cycles a non-empty buffer may go unserved before stall_req asserts.
- CNT_W, 3, starvation counter width; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wb_we  in  1  WB stage write enable
- wb_waddr  in  5  WB destination register
- wb_wdata  in  32  WB write data
- mdu_valid  in  1  MDU result valid
- mdu_ready  out  1  buffer can accept a result
- mdu_waddr  in  5  MDU destination register
- mdu_wdata  in  32  MDU result
- rf_we  out  1  regfile write enable
- rf_waddr  out  5  regfile write address
- rf_wdata  out  32  regfile write data
- stall_req  out  1  request to freeze the pipeline (registered)
- mdu_pending  out  1  buffer non-empty

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset state: buffer empty (rd_ptr=wr_ptr=count=0, all entry valid bits 0), wait_cnt=0, stall_req=0.
- Write enable while rst=1: rf_we is forced to 0.
- Write-port grant (combinational, same cycle):
  - WB slot: wb_act = wb_we && wb_waddr!=0.
  - If wb_act: rf_* = wb_*.
  - Else if the head entry is valid: rf_* = head entry, and the entry pops at the clock edge.
  - Else: rf_we=0, rf_waddr=0, rf_wdata=0.
- Head entry killed: it pops silently, with rf_we=0 that cycle.
- Accept: mdu_ready = (count<DEPTH). It does not depend on a same-cycle pop; there is no full-bypass path.
  - Push on mdu_valid && mdu_ready. The entry is stored with valid = (mdu_waddr!=0).
  - A $0 result therefore occupies a slot but is never written.
- No bypass from an empty buffer: an accepted MDU result reaches rf_we at the earliest 1 cycle after acceptance.
- Simultaneous push and pop: both occur; count is unchanged and the pointers advance, each wrapping modulo DEPTH.
- WAW kill: when wb_act and wb_waddr matches a valid buffered entry's address, that entry's valid bit clears at the edge.
  - WB is architecturally younger than any buffered MDU result.
  - An entry pushed in the same cycle with a matching address is also stored invalid.
- Starvation counter:
  - wait_cnt resets to 0 on a pop or when the buffer is empty.
  - Otherwise wait_cnt increments, saturating at MAX_WAIT.
  - stall_req (registered) = 1 in the cycle after wait_cnt reaches MAX_WAIT.
  - stall_req clears the cycle after the next pop.
  - The pipeline answers a stall by presenting wb_we=0 (bubble); that bubble cycle pops the head.
- mdu_pending = (count!=0).
- Reset mid-operation: all buffered results are discarded; the MDU side is expected to reset on the same rst.

Decomposition:
- Shared package constants: REG_W=5, DATA_W=32, REG_ZERO=5'd0.
- One natural sub-module, wport_fifo: DEPTH-entry buffer with per-entry valid bits, an address-match kill port, and push/pop/count.
- Arbitration and starvation logic stay in the top module.

Test Plan:
1. Reset, then wb_we=1, waddr=5, wdata=0x1234 -> same cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; stall_req=0, mdu_ready=1.
2. MDU push (waddr=8, data=0xCAFE) with wb_we=0 -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0xCAFE; mdu_pending drops the cycle after.
3. Two MDU pushes while wb_we=1 continuously -> mdu_ready=0 after the second push; wait_cnt reaches 4; stall_req=1 the next cycle. Then drive wb_we=0 -> head (first push) written; stall_req=0 the following cycle.
4. Buffer entry waddr=9, then WB writes reg 9 in the same cycle the head would pop -> rf_waddr=9 carries the WB data; the buffered entry is killed and never written; count decrements on its later silent pop.
5. MDU result to $0 -> accepted and popped; rf_we never asserts for it. WB write to $0 -> rf_we=0 that cycle and the head drains instead.
6. Full buffer with rst=1 for one cycle -> next cycle mdu_pending=0, mdu_ready=1, stall_req=0, no stale write appears.
